// File: rtl/rgb_status_ctrl_pkg.sv
// Shared encodings for the status-light controller: LED channel width,
// display modes, arbiter states and a counter-width helper.
package rgb_status_ctrl_pkg;

  localparam int LED_NBPC = 8;

  typedef enum logic [1:0] {
    RGB_MODE_SOLID   = 2'b00,
    RGB_MODE_BLINK   = 2'b01,
    RGB_MODE_BREATHE = 2'b10,
    RGB_MODE_DARK    = 2'b11
  } rgb_mode_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_e;

  // Bits needed for a counter that must hold every value 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rgb_pattern.sv
// Display-pattern generator: blink phase, breathe ramp and channel scaling,
// producing a registered colour for the LED driver.
module rgb_pattern
  import rgb_status_ctrl_pkg::*;
#(
  parameter int NBPC        = LED_NBPC,
  parameter int BLINK_TICKS = 250
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              restart,
  input  rgb_mode_e         mode,
  input  logic [3*NBPC-1:0] color,
  output logic [3*NBPC-1:0] rgb
);

  localparam int              BW         = cnt_width(BLINK_TICKS - 1);
  localparam logic [BW-1:0]   BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [NBPC-1:0] LEVEL_MAX  = '1;

  logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
  logic              blink_on_q, blink_on_d;
  logic [NBPC-1:0]   level_q, level_d;
  logic              level_up_q, level_up_d;
  logic [3*NBPC-1:0] rgb_q, rgb_d;
  logic [3*NBPC-1:0] scaled;
  logic [2*NBPC-1:0] prod;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    level_d     = level_q;
    level_up_d  = level_up_q;
    if (restart) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
      level_d     = '0;
      level_up_d  = 1'b1;
    end else if (tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_on_d  = !blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
      // Direction flips as an endpoint is entered, so each endpoint lasts one tick.
      if (level_up_q) begin
        level_d = level_q + 1'b1;
        if (level_q == LEVEL_MAX - 1'b1) level_up_d = 1'b0;
      end else begin
        level_d = level_q - 1'b1;
        if (level_q == NBPC'(1)) level_up_d = 1'b1;
      end
    end
  end

  always_comb begin
    scaled = '0;
    prod   = '0;
    for (int ch = 0; ch < 3; ch++) begin
      prod = {{NBPC{1'b0}}, color[ch*NBPC +: NBPC]} * {{NBPC{1'b0}}, level_q};
      scaled[ch*NBPC +: NBPC] = prod[2*NBPC-1:NBPC];
    end
  end

  always_comb begin
    rgb_d = '0;
    case (mode)
      RGB_MODE_SOLID:   rgb_d = color;
      RGB_MODE_BLINK:   rgb_d = blink_on_q ? color : '0;
      RGB_MODE_BREATHE: rgb_d = scaled;
      RGB_MODE_DARK:    rgb_d = '0;
      default:          rgb_d = '0;
    endcase
  end

  // NOTE: reset is synchronous and active-high to match the rest of this
  // codebase; state registers use non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      level_q     <= '0;
      level_up_q  <= 1'b1;
      rgb_q       <= '0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      level_q     <= level_d;
      level_up_q  <= level_up_d;
      rgb_q       <= rgb_d;
    end
  end

  assign rgb = rgb_q;

endmodule

// File: rtl/rgb_status_ctrl.sv
// Status-light controller: fixed-priority arbitration with a minimum hold
// time over the shared RGB LED driver, plus display-pattern generation.
module rgb_status_ctrl
  import rgb_status_ctrl_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int NBPC        = LED_NBPC,
  parameter int TICK_DIV    = 12000,
  parameter int BLINK_TICKS = 250,
  parameter int HOLD_TICKS  = 100
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_i,
  input  logic [NREQ*3*NBPC-1:0] color_i,
  input  logic [NREQ*2-1:0]      mode_i,
  output logic [NREQ-1:0]        grant_o,
  output logic [3*NBPC-1:0]      rgb_o,
  output logic                   en_o
);

  localparam int            CW         = 3 * NBPC;
  localparam int            PW         = cnt_width(TICK_DIV - 1);
  localparam int            HW         = cnt_width(HOLD_TICKS);
  localparam int            IW         = cnt_width(NREQ - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_TICKS);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  arb_state_e    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          en_q, en_d;
  logic          restart;
  logic          any_req;
  logic [IW-1:0] top_idx;
  logic [CW-1:0] owner_color;
  rgb_mode_e     owner_mode;

  // Free-running prescaler; only rst realigns it, so a new owner's first tick may be short.
  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  always_comb begin
    any_req = |req_i;
    top_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_i[k]) top_idx = IW'(k);
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    restart = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          state_d = ARB_OWN;
          owner_d = top_idx;
          restart = 1'b1;
        end
      end
      ARB_OWN: begin
        if (!req_i[owner_q]) begin
          restart = 1'b1;
          if (any_req) owner_d = top_idx;
          else         state_d = ARB_IDLE;
        end else if (hold_q == HOLD_MAX && top_idx < owner_q) begin
          owner_d = top_idx;
          restart = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    hold_d = hold_q;
    if (restart)                                              hold_d = '0;
    else if (state_q == ARB_OWN && tick && hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;

    en_d = (state_q == ARB_OWN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      state_q <= ARB_IDLE;
      owner_q <= '0;
      hold_q  <= '0;
      en_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      state_q <= state_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      en_q    <= en_d;
    end
  end

  // Owner's colour and mode are sampled live; idle forces black so rgb_o clears on release.
  always_comb begin
    owner_color = '0;
    owner_mode  = RGB_MODE_SOLID;
    grant_o     = '0;
    if (state_q == ARB_OWN) begin
      owner_color      = color_i[int'(owner_q)*CW +: CW];
      owner_mode       = rgb_mode_e'(mode_i[int'(owner_q)*2 +: 2]);
      grant_o[owner_q] = 1'b1;
    end
  end

  rgb_pattern #(
    .NBPC        (NBPC),
    .BLINK_TICKS (BLINK_TICKS)
  ) u_pattern (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .restart (restart),
    .mode    (owner_mode),
    .color   (owner_color),
    .rgb     (rgb_o)
  );

  assign en_o = en_q;

endmodule

// File: tb/tb_rgb_status_ctrl.sv
// Directed testbench for rgb_status_ctrl with short tick, blink and hold
// periods so every pattern and arbitration edge is reachable quickly.
module tb_rgb_status_ctrl;

  localparam int NREQ        = 4;
  localparam int NBPC        = 8;
  localparam int TICK_DIV    = 4;
  localparam int BLINK_TICKS = 3;
  localparam int HOLD_TICKS  = 5;
  localparam int CW          = 3 * NBPC;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_i;
  logic [NREQ*CW-1:0]   color_i;
  logic [NREQ*2-1:0]    mode_i;
  logic [NREQ-1:0]      grant_o;
  logic [CW-1:0]        rgb_o;
  logic                 en_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  rgb_status_ctrl #(
    .NREQ        (NREQ),
    .NBPC        (NBPC),
    .TICK_DIV    (TICK_DIV),
    .BLINK_TICKS (BLINK_TICKS),
    .HOLD_TICKS  (HOLD_TICKS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req_i),
    .color_i (color_i),
    .mode_i  (mode_i),
    .grant_o (grant_o),
    .rgb_o   (rgb_o),
    .en_o    (en_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  // Cycle k means 1 time unit after the k-th rising edge following reset.
  task automatic step_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst   = 1'b1;
    req_i = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic set_src(input int idx, input logic [23:0] c, input logic [1:0] m);
    color_i[idx*CW +: CW] = c;
    mode_i[idx*2 +: 2]    = m;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (grant_o !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", grant_o); end
    checks++;
    if (rgb_o !== 24'h000000) begin errors++; $display("FAIL reset_rgb: got %h expected 000000", rgb_o); end
    checks++;
    if (en_o !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", en_o); end
    step_to(6);
    checks++;
    if (grant_o !== 4'b0000 || en_o !== 1'b0) begin
      errors++; $display("FAIL idle_no_req: got grant %b en %b expected 0000 0", grant_o, en_o);
    end
  endtask

  task automatic test_solid_release();
    do_reset();
    set_src(2, 24'h102030, 2'b00);
    req_i = 4'b0100;
    step_to(1);
    checks++;
    if (grant_o !== 4'b0100) begin errors++; $display("FAIL solid_grant: got %b expected 0100", grant_o); end
    checks++;
    if (en_o !== 1'b0) begin errors++; $display("FAIL solid_en_latency: got %b expected 0", en_o); end
    step_to(2);
    checks++;
    if (rgb_o !== 24'h102030) begin errors++; $display("FAIL solid_rgb: got %h expected 102030", rgb_o); end
    checks++;
    if (en_o !== 1'b1) begin errors++; $display("FAIL solid_en: got %b expected 1", en_o); end
    step_to(10);
    req_i = 4'b0000;
    step_to(11);
    checks++;
    if (grant_o !== 4'b0000) begin errors++; $display("FAIL release_grant: got %b expected 0000", grant_o); end
    checks++;
    if (en_o !== 1'b1) begin errors++; $display("FAIL release_en_pipe: got %b expected 1", en_o); end
    step_to(12);
    checks++;
    if (en_o !== 1'b0 || rgb_o !== 24'h000000) begin
      errors++; $display("FAIL release_out: got en %b rgb %h expected 0 000000", en_o, rgb_o);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    set_src(2, 24'h102030, 2'b00);
    req_i = 4'b0100;
    step_to(3);
    checks++;
    if (rgb_o !== 24'h102030) begin errors++; $display("FAIL midrst_pre_rgb: got %h expected 102030", rgb_o); end
    rst = 1'b1;
    step_to(4);
    rst = 1'b0;
    checks++;
    if (grant_o !== 4'b0000 || rgb_o !== 24'h000000 || en_o !== 1'b0) begin
      errors++; $display("FAIL midrst_out: got grant %b rgb %h en %b expected 0000 000000 0", grant_o, rgb_o, en_o);
    end
    step_to(5);
    checks++;
    if (grant_o !== 4'b0100) begin errors++; $display("FAIL midrst_regrant: got %b expected 0100", grant_o); end
    req_i = 4'b0000;
  endtask

  task automatic test_dark_live_mode();
    do_reset();
    set_src(1, 24'hABCDEF, 2'b11);
    req_i = 4'b0010;
    step_to(2);
    checks++;
    if (grant_o !== 4'b0010 || en_o !== 1'b1 || rgb_o !== 24'h000000) begin
      errors++; $display("FAIL dark_out: got grant %b en %b rgb %h expected 0010 1 000000", grant_o, en_o, rgb_o);
    end
    set_src(1, 24'hABCDEF, 2'b00);
    step_to(3);
    checks++;
    if (rgb_o !== 24'hABCDEF) begin errors++; $display("FAIL live_mode_rgb: got %h expected abcdef", rgb_o); end
    req_i = 4'b0000;
  endtask

  task automatic test_hold_preempt();
    int unsigned chk_cyc [4] = '{5, 19, 20, 21};
    logic [3:0]  exp_gnt [4] = '{4'b1000, 4'b1000, 4'b1000, 4'b0001};
    do_reset();
    set_src(3, 24'h0000FF, 2'b00);
    set_src(0, 24'h00FF00, 2'b00);
    req_i = 4'b1000;
    step_to(4);
    req_i = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      step_to(int'(chk_cyc[i]));
      checks++;
      if (grant_o !== exp_gnt[i]) begin
        errors++; $display("FAIL hold_grant cyc %0d: got %b expected %b", cyc, grant_o, exp_gnt[i]);
      end
    end
    step_to(22);
    checks++;
    if (rgb_o !== 24'h00FF00) begin errors++; $display("FAIL preempt_rgb: got %h expected 00ff00", rgb_o); end
    req_i = 4'b0000;
  endtask

  task automatic test_no_low_preempt();
    do_reset();
    set_src(1, 24'h123456, 2'b00);
    set_src(2, 24'h654321, 2'b00);
    req_i = 4'b0010;
    step_to(4);
    req_i = 4'b0110;
    step_to(21);
    checks++;
    if (grant_o !== 4'b0010) begin errors++; $display("FAIL nopreempt_21: got %b expected 0010", grant_o); end
    step_to(40);
    checks++;
    if (grant_o !== 4'b0010) begin errors++; $display("FAIL nopreempt_40: got %b expected 0010", grant_o); end
    req_i = 4'b0000;
  endtask

  task automatic test_drop_simultaneous();
    do_reset();
    set_src(0, 24'h00FF00, 2'b00);
    set_src(1, 24'h111111, 2'b00);
    set_src(3, 24'h0000FF, 2'b00);
    req_i = 4'b0010;
    step_to(3);
    checks++;
    if (grant_o !== 4'b0010) begin errors++; $display("FAIL simul_pre: got %b expected 0010", grant_o); end
    req_i = 4'b1001;
    step_to(4);
    checks++;
    if (grant_o !== 4'b0001 || en_o !== 1'b1) begin
      errors++; $display("FAIL simul_switch: got grant %b en %b expected 0001 1", grant_o, en_o);
    end
    step_to(5);
    checks++;
    if (rgb_o !== 24'h00FF00 || en_o !== 1'b1) begin
      errors++; $display("FAIL simul_rgb: got rgb %h en %b expected 00ff00 1", rgb_o, en_o);
    end
    req_i = 4'b0000;
  endtask

  task automatic test_blink();
    int unsigned chk_cyc [8] = '{2, 12, 13, 24, 25, 36, 37, 48};
    logic [23:0] exp_rgb [8] = '{24'hFF0000, 24'hFF0000, 24'h000000, 24'h000000,
                                 24'hFF0000, 24'hFF0000, 24'h000000, 24'h000000};
    do_reset();
    set_src(0, 24'hFF0000, 2'b01);
    req_i = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      step_to(int'(chk_cyc[i]));
      checks++;
      if (rgb_o !== exp_rgb[i] || en_o !== 1'b1) begin
        errors++; $display("FAIL blink cyc %0d: got rgb %h en %b expected %h 1", cyc, rgb_o, en_o, exp_rgb[i]);
      end
    end
    req_i = 4'b0000;
  endtask

  task automatic test_breathe();
    int unsigned chk_cyc [11] = '{2, 5, 9, 513, 1021, 1024, 1025, 2033, 2041, 2045, 2049};
    logic [23:0] exp_rgb [11] = '{24'h000000, 24'h000000, 24'h010101, 24'h7F7F7F,
                                  24'hFEFEFE, 24'hFEFEFE, 24'hFDFDFD, 24'h010101,
                                  24'h000000, 24'h000000, 24'h010101};
    do_reset();
    set_src(0, 24'hFFFFFF, 2'b10);
    req_i = 4'b0001;
    for (int i = 0; i < 11; i++) begin
      step_to(int'(chk_cyc[i]));
      checks++;
      if (rgb_o !== exp_rgb[i]) begin
        errors++; $display("FAIL breathe cyc %0d: got %h expected %h", cyc, rgb_o, exp_rgb[i]);
      end
    end
    req_i = 4'b0000;
  endtask

  initial begin
    rst     = 1'b1;
    req_i   = '0;
    color_i = '0;
    mode_i  = '0;
    test_reset();
    test_solid_release();
    test_reset_mid_grant();
    test_dark_live_mode();
    test_hold_preempt();
    test_no_low_preempt();
    test_drop_simultaneous();
    test_blink();
    test_breathe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
